// File: rtl/wb_serial_divider_sx_if.sv
// ---------------------------------------------------------------------------
// wb_serial_divider_sx_if
//   Wishbone slave bus bundle for the serial divider.
//   Signal names keep the Caravel user-project wrapper naming so the bundle
//   maps one-to-one onto the wrapper's wbs_* nets.
//
//   wbs_stb_i  strobe           wbs_cyc_i  cycle
//   wbs_we_i   write enable     wbs_sel_i  byte selects (WBW/8)
//   wbs_adr_i  address (WBW)    wbs_dat_i  write data (WBW)
//   wbs_ack_o  ack, registered  wbs_dat_o  read data, valid with ack
//
//   Handshake: a transfer is accepted on a clock edge where stb & cyc are
//   high, the address decodes to this block and ack is low; ack is high for
//   exactly the following cycle, so a master holding stb sees one ack per
//   transfer and never two acks back to back.
// ---------------------------------------------------------------------------
interface wb_serial_divider_sx_if #(
  parameter int WBW = 32
);
  logic             wbs_stb_i;
  logic             wbs_cyc_i;
  logic             wbs_we_i;
  logic [WBW/8-1:0] wbs_sel_i;
  logic [WBW-1:0]   wbs_adr_i;
  logic [WBW-1:0]   wbs_dat_i;
  logic             wbs_ack_o;
  logic [WBW-1:0]   wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_serial_divider_sx.sv
// ---------------------------------------------------------------------------
// wb_serial_divider_sx
//   Wishbone-mapped radix-2 restoring divider, XLEN bits, signed/unsigned,
//   RISC-V divide-by-zero results, busy/done status with W1C done and a
//   level interrupt.
//
// Ports
//   wb_clk_i   clock
//   wb_rst_i   synchronous active-high reset (aborts an operation in flight)
//   wbs        Wishbone slave bundle (wb_serial_divider_sx_if.slave)
//   la_data_o  debug: {0.., cnt[5:0], state[2:0], dz, done, busy}
//   irq_o      done & CTRL.irq_en
//   start_o    one-cycle pulse when the FSM enters PREP
//   fini_o     one-cycle pulse on the cycle done becomes 1
//
// Register map (offset = adr[4:2])
//   0x00 DIVIDEND rw   0x04 DIVISOR rw
//   0x08 CTRL     b0 start (self-clearing, reads 0), b1 signed, b2 irq_en
//   0x0C STATUS   b0 busy, b1 done (W1C), b2 dz
//   0x10 QUOT ro  0x14 REM ro     other offsets read 0
//
// Timing with start accepted on cycle C: PREP at C+1, RUN for XLEN cycles,
// FIX, then IDLE with done=1 at C+XLEN+3 (C+3 for a zero divisor).
// ---------------------------------------------------------------------------
module wb_serial_divider_sx #(
  parameter int             WBW      = 32,
  parameter int             LAW      = 32,
  parameter int             XLEN     = 32,
  parameter logic [WBW-1:0] BASE_ADR = 'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_serial_divider_sx_if.slave wbs,
  output logic [LAW-1:0]        la_data_o,
  output logic                  irq_o,
  output logic                  start_o,
  output logic                  fini_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3
  } state_t;

  localparam logic [2:0] OFF_DVD  = 3'd0;
  localparam logic [2:0] OFF_DVS  = 3'd1;
  localparam logic [2:0] OFF_CTRL = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_QUOT = 3'd4;
  localparam logic [2:0] OFF_REM  = 3'd5;

  // Programmer-visible registers
  state_t          r_state;
  logic            r_ack;
  logic [WBW-1:0]  r_dat;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem_o;
  logic            r_signed;
  logic            r_irq_en;
  logic            r_done;
  logic            r_dz;
  logic            r_start;
  logic            r_fini;

  // Datapath working registers. r_dvd starts as |dividend| and is shifted
  // left each step with the new quotient bit entering at the bottom, so it
  // holds the quotient magnitude once RUN completes.
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [7:0]      r_cnt;

  logic            w_decode;
  logic            w_access;
  logic            w_wr;
  logic            w_rd;
  logic [2:0]      w_off;
  logic [WBW-1:0]  w_wmask;
  logic [WBW-1:0]  w_dvd_wr;
  logic [WBW-1:0]  w_dvs_wr;
  logic [WBW-1:0]  w_rdata;
  logic            w_busy;
  logic            w_start;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_abs;
  logic [XLEN-1:0] w_b_abs;
  logic [XLEN:0]   w_trial;
  logic [XLEN:0]   w_diff;
  logic            w_qbit;
  logic            w_unused;

  // ---------------- Bus decode ----------------
  assign w_decode = (wbs.wbs_adr_i[WBW-1:8] == BASE_ADR[WBW-1:8]);
  assign w_access = wbs.wbs_stb_i & wbs.wbs_cyc_i & w_decode & ~r_ack;
  assign w_wr     = w_access & wbs.wbs_we_i;
  assign w_rd     = w_access & ~wbs.wbs_we_i;
  assign w_off    = wbs.wbs_adr_i[4:2];
  assign w_busy   = (r_state != S_IDLE);

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < WBW / 8; i++) begin
      w_wmask[i*8 +: 8] = {8{wbs.wbs_sel_i[i]}};
    end
  end

  // Byte-lane merge of write data into the current operand value
  assign w_dvd_wr = (WBW'(r_dividend) & ~w_wmask) | (wbs.wbs_dat_i & w_wmask);
  assign w_dvs_wr = (WBW'(r_divisor)  & ~w_wmask) | (wbs.wbs_dat_i & w_wmask);

  // A start request while busy is dropped; mode bits are still written.
  assign w_start = w_wr && (w_off == OFF_CTRL) && wbs.wbs_sel_i[0] &&
                   wbs.wbs_dat_i[0] && (r_state == S_IDLE);

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_DVD:  w_rdata = WBW'(r_dividend);
      OFF_DVS:  w_rdata = WBW'(r_divisor);
      OFF_CTRL: w_rdata = WBW'({r_irq_en, r_signed, 1'b0});
      OFF_STAT: w_rdata = WBW'({r_dz, r_done, w_busy});
      OFF_QUOT: w_rdata = WBW'(r_quot);
      OFF_REM:  w_rdata = WBW'(r_rem_o);
      default:  w_rdata = '0;
    endcase
  end

  // ---------------- Datapath helpers ----------------
  assign w_a_neg = r_signed & r_dividend[XLEN-1];
  assign w_b_neg = r_signed & r_divisor[XLEN-1];
  // XLEN-bit negate: abs(MIN) stays MIN, which read as unsigned is the
  // correct magnitude, so MIN / -1 needs no special handling.
  assign w_a_abs = w_a_neg ? -r_dividend : r_dividend;
  assign w_b_abs = w_b_neg ? -r_divisor  : r_divisor;

  // Partial remainder is always < divisor, so one extra bit suffices
  // for the shifted trial value.
  assign w_trial = {r_acc, r_dvd[XLEN-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};
  assign w_qbit  = ~w_diff[XLEN];

  // ---------------- Registers and FSM ----------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem_o    <= '0;
      r_signed   <= 1'b0;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_start    <= 1'b0;
      r_fini     <= 1'b0;
      r_acc      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ack   <= w_access;
      r_dat   <= w_rd ? w_rdata : '0;
      r_start <= 1'b0;
      r_fini  <= 1'b0;

      // Register writes come first so the FSM's done set below overrides
      // a W1C landing on the same edge.
      if (w_wr) begin
        case (w_off)
          OFF_DVD: r_dividend <= w_dvd_wr[XLEN-1:0];
          OFF_DVS: r_divisor  <= w_dvs_wr[XLEN-1:0];
          OFF_CTRL: begin
            if (wbs.wbs_sel_i[0]) begin
              r_signed <= wbs.wbs_dat_i[1];
              r_irq_en <= wbs.wbs_dat_i[2];
            end
          end
          OFF_STAT: begin
            if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[1]) r_done <= 1'b0;
          end
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_PREP;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_start <= 1'b1;
          end
        end
        S_PREP: begin
          r_cnt   <= '0;
          r_acc   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          if (r_divisor == '0) begin
            // Keep the raw dividend: it is the remainder result.
            r_dz    <= 1'b1;
            r_dvd   <= r_dividend;
            r_state <= S_FIX;
          end else begin
            r_dvd   <= w_a_abs;
            r_dvs   <= w_b_abs;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_qbit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
          r_dvd <= {r_dvd[XLEN-2:0], w_qbit};
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == 8'(XLEN - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_dz) begin
            r_quot  <= '1;
            r_rem_o <= r_dvd;
          end else begin
            r_quot  <= r_neg_q ? -r_dvd : r_dvd;
            r_rem_o <= r_neg_r ? -r_acc : r_acc;
          end
          r_done  <= 1'b1;
          r_fini  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;
  assign irq_o         = r_done & r_irq_en;
  assign start_o       = r_start;
  assign fini_o        = r_fini;
  assign la_data_o     = LAW'({r_cnt[5:0], r_state, r_dz, r_done, w_busy});

  // Address bits outside the decode/offset fields and merge bits above XLEN
  // carry no function.
  assign w_unused = ^{wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0], w_dvd_wr, w_dvs_wr};

endmodule

// File: tb/tb_wb_serial_divider_sx.sv
// ---------------------------------------------------------------------------
// tb_wb_serial_divider_sx
//   Self-checking bench for wb_serial_divider_sx (XLEN = 32). Each test task
//   drives the Wishbone bus, pushes the expected {quot, rem} for every started
//   operation onto exp_q, and pops/compares when the operation completes.
// ---------------------------------------------------------------------------
module tb_wb_serial_divider_sx;
  localparam int          WBW    = 32;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_DVD  = BASE + 32'h00;
  localparam logic [31:0] A_DVS  = BASE + 32'h04;
  localparam logic [31:0] A_CTRL = BASE + 32'h08;
  localparam logic [31:0] A_STAT = BASE + 32'h0C;
  localparam logic [31:0] A_QUOT = BASE + 32'h10;
  localparam logic [31:0] A_REM  = BASE + 32'h14;
  localparam logic [31:0] A_UNM  = BASE + 32'h18;

  // ---------------- Clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] la;
  logic        irq;
  logic        start_p;
  logic        fini_p;

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  wb_serial_divider_sx_if #(.WBW(WBW)) bus ();

  wb_serial_divider_sx #(
    .WBW(32), .LAW(32), .XLEN(32), .BASE_ADR(BASE)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (bus),
    .la_data_o (la),
    .irq_o     (irq),
    .start_o   (start_p),
    .fini_o    (fini_p)
  );

  // ---------------- Scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  logic [31:0] rd;

  int          op_c0;
  int          op_cycles;
  logic        op_start, op_busy, op_gap, op_fini;
  logic [31:0] op_q, op_r;

  // Reference division: RISC-V semantics built on SV's truncating / and %.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  // ---------------- Driver tasks ----------------
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bit got = 1'b0;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_sel_i = sel;
    bus.wbs_we_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.wbs_ack_o;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL wb_write_ack adr=%h: ack=0 after 8 cycles, required 1", adr);
    end
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    bit got = 1'b0;
    bus.wbs_adr_i = adr; bus.wbs_sel_i = 4'hF; bus.wbs_we_i = 1'b0;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1;
    dat = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.wbs_ack_o;
      dat = bus.wbs_dat_o;
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL wb_read_ack adr=%h: ack=0 after 8 cycles, required 1", adr);
    end
  endtask

  // Writes operands and CTRL with start; returns in cycle C+1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic ien);
    exp_q.push_back(model(a, b, sgn));
    wb_write(A_DVD, a, 4'hF);
    wb_write(A_DVS, b, 4'hF);
    wb_write(A_CTRL, {29'd0, ien, sgn, 1'b1}, 4'hF);
    op_c0    = cyc_cnt;
    op_start = start_p;
    op_busy  = la[0];
  endtask

  // Waits for done; op_cycles is the cycle offset from C at which it appears.
  task automatic wait_done();
    op_gap = 1'b0;
    while (!la[1] && (cyc_cnt - op_c0) < 200) begin
      if (!la[0]) op_gap = 1'b1;
      @(posedge clk); #1;
    end
    op_cycles = cyc_cnt - op_c0 + 1;
    op_fini   = fini_p;
    if (!la[1]) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: done=0 after 200 cycles, required 1");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic ien);
    start_op(a, b, sgn, ien);
    wait_done();
    wb_read(A_QUOT, op_q);
    wb_read(A_REM, op_r);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    n_tests++; if (la !== 32'd0) begin n_fail++; $display("FAIL reset_la: got %h required %h", la, 32'd0); end
    n_tests++; if ({irq, start_p, fini_p} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b required 000", {irq, start_p, fini_p}); end
    wb_read(A_STAT, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h required 0", rd); end
    wb_read(A_QUOT, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_quot: got %h required 0", rd); end
    wb_read(A_REM, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_rem: got %h required 0", rd); end
    wb_read(A_DVD, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_dividend: got %h required 0", rd); end
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (op_start !== 1'b1) begin n_fail++; $display("FAIL udiv_start_pulse: got %b required 1", op_start); end
    n_tests++; if (op_busy !== 1'b1) begin n_fail++; $display("FAIL udiv_busy_c1: got %b required 1", op_busy); end
    n_tests++; if (op_gap !== 1'b0) begin n_fail++; $display("FAIL udiv_busy_gap: got %b required 0", op_gap); end
    n_tests++; if (op_cycles !== 35) begin n_fail++; $display("FAIL udiv_done_cycle: got C+%0d required C+35", op_cycles); end
    n_tests++; if (op_fini !== 1'b1) begin n_fail++; $display("FAIL udiv_fini: got %b required 1", op_fini); end
    n_tests++; if (op_q !== e[63:32]) begin n_fail++; $display("FAIL udiv_quot: got %h required %h", op_q, e[63:32]); end
    n_tests++; if (op_r !== e[31:0]) begin n_fail++; $display("FAIL udiv_rem: got %h required %h", op_r, e[31:0]); end
    n_tests++; if (fini_p !== 1'b0) begin n_fail++; $display("FAIL udiv_fini_width: got %b required 0", fini_p); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL udiv_irq_off: got %b required 0", irq); end
    n_tests++; if (la[0] !== 1'b0) begin n_fail++; $display("FAIL udiv_busy_after: got %b required 0", la[0]); end
    run_op(32'd100, 32'd7, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL udiv_irq_on: got %b required 1", irq); end
    n_tests++; if (op_q !== e[63:32]) begin n_fail++; $display("FAIL udiv2_quot: got %h required %h", op_q, e[63:32]); end
  endtask

  task automatic test_signed();
    logic [31:0] sa[3] = '{32'hFFFF_FF9C, 32'd100, 32'h8000_0000};
    logic [31:0] sb[3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      run_op(sa[i], sb[i], 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_tests++; if (op_q !== e[63:32]) begin n_fail++; $display("FAIL sdiv_quot[%0d]: got %h required %h", i, op_q, e[63:32]); end
      n_tests++; if (op_r !== e[31:0]) begin n_fail++; $display("FAIL sdiv_rem[%0d]: got %h required %h", i, op_r, e[31:0]); end
    end
    // Same MIN / all-ones operands in unsigned mode
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if ({op_q, op_r} !== e) begin n_fail++; $display("FAIL udiv_min: got %h required %h", {op_q, op_r}, e); end
  endtask

  task automatic test_div_zero();
    run_op(32'h0000_1234, 32'd0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if (op_cycles !== 3) begin n_fail++; $display("FAIL dz_done_cycle: got C+%0d required C+3", op_cycles); end
    n_tests++; if (op_fini !== 1'b1) begin n_fail++; $display("FAIL dz_fini: got %b required 1", op_fini); end
    n_tests++; if ({op_q, op_r} !== e) begin n_fail++; $display("FAIL dz_result: got %h required %h", {op_q, op_r}, e); end
    wb_read(A_STAT, rd);
    n_tests++; if (rd !== 32'h6) begin n_fail++; $display("FAIL dz_status: got %h required %h", rd, 32'h6); end
    run_op(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_tests++; if ({op_q, op_r} !== e) begin n_fail++; $display("FAIL dz_signed: got %h required %h", {op_q, op_r}, e); end
    // A normal op afterwards clears dz
    run_op(32'd9, 32'd3, 1'b0, 1'b0);
    e = exp_q.pop_front();
    wb_read(A_STAT, rd);
    n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL dz_cleared: got %h required %h", rd, 32'h2); end
  endtask

  task automatic test_busy_start_ignored();
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    // Accepted on C+5: start dropped, signed mode written, operands replaced
    wb_write(A_CTRL, 32'h3, 4'hF);
    wb_write(A_DVD, 32'd999, 4'hF);
    wait_done();
    wb_read(A_QUOT, op_q);
    wb_read(A_REM, op_r);
    e = exp_q.pop_front();
    n_tests++; if (op_cycles !== 35) begin n_fail++; $display("FAIL busy_start_timing: got C+%0d required C+35", op_cycles); end
    n_tests++; if ({op_q, op_r} !== e) begin n_fail++; $display("FAIL busy_start_result: got %h required %h", {op_q, op_r}, e); end
    wb_read(A_CTRL, rd);
    n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL busy_ctrl_mode: got %h required %h", rd, 32'h2); end
    wb_read(A_DVD, rd);
    n_tests++; if (rd !== 32'd999) begin n_fail++; $display("FAIL busy_operand_write: got %h required %h", rd, 32'd999); end
  endtask

  task automatic test_reset_mid_op();
    logic saw_fini = 1'b0;
    logic saw_done = 1'b0;
    wb_write(A_DVD, 32'd100, 4'hF);
    wb_write(A_DVS, 32'd7, 4'hF);
    wb_write(A_CTRL, 32'h1, 4'hF);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (la[1:0] !== 2'b00) begin n_fail++; $display("FAIL rst_mid_status: got %b required 00", la[1:0]); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (fini_p) saw_fini = 1'b1;
      if (la[1]) saw_done = 1'b1;
    end
    n_tests++; if ({saw_fini, saw_done} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_no_fini: got %b required 00", {saw_fini, saw_done}); end
    wb_read(A_QUOT, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_mid_quot: got %h required 0", rd); end
  endtask

  task automatic test_byte_select();
    wb_write(A_DVD, 32'h1122_3344, 4'hF);
    wb_write(A_DVD, 32'h0000_00AA, 4'b0001);
    wb_read(A_DVD, rd);
    n_tests++; if (rd !== 32'h1122_33AA) begin n_fail++; $display("FAIL sel_byte0: got %h required %h", rd, 32'h1122_33AA); end
    wb_write(A_DVD, 32'hFF55_FFFF, 4'b0100);
    wb_read(A_DVD, rd);
    n_tests++; if (rd !== 32'h1155_33AA) begin n_fail++; $display("FAIL sel_byte2: got %h required %h", rd, 32'h1155_33AA); end
    wb_read(A_UNM, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h required 0", rd); end
  endtask

  task automatic test_w1c_irq();
    run_op(32'd50, 32'd5, 1'b0, 1'b1);
    e = exp_q.pop_front();
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_set: got %b required 1", irq); end
    // Byte lane 0 not selected: done must survive
    wb_write(A_STAT, 32'h2, 4'b0010);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_sel_ignored: got %b required 1", irq); end
    wb_write(A_STAT, 32'h2, 4'b0001);
    wb_read(A_STAT, rd);
    n_tests++; if (rd !== 32'd0) begin n_fail++; $display("FAIL w1c_status: got %h required 0", rd); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_clear: got %b required 0", irq); end
    wb_read(A_QUOT, rd);
    n_tests++; if (rd !== e[63:32]) begin n_fail++; $display("FAIL w1c_quot_hold: got %h required %h", rd, e[63:32]); end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        sgn;
    for (int i = 0; i < 10; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 9);
        default: b = $urandom;
      endcase
      run_op(a, b, sgn, 1'b0);
      e = exp_q.pop_front();
      n_tests++; if ({op_q, op_r} !== e) begin n_fail++; $display("FAIL rand[%0d] %h/%h s=%b: got %h required %h", i, a, b, sgn, {op_q, op_r}, e); end
      n_tests++; if (op_cycles !== ((b == 32'd0) ? 3 : 35)) begin n_fail++; $display("FAIL rand_timing[%0d]: got C+%0d required C+%0d", i, op_cycles, (b == 32'd0) ? 3 : 35); end
    end
  endtask

  // ---------------- Sequence ----------------
  initial begin
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_busy_start_ignored();
    test_reset_mid_op();
    test_byte_select();
    test_w1c_irq();
    test_random();
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
